impact_array_seq: RTL and testbench

// Sequencer for the user_proj_IMPACT_HEAD in-memory array. Accepts one read/write command
// at a time over a valid/ready interface. Generates the PreCharge -> WL_enable ->

---
 rtl/impact_array_seq.sv | 162 ++++++++++++++++
 tb/tb_impact_array_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/impact_array_seq.sv
// impact_array_seq: one-command-at-a-time sequencer for the IMPACT_HEAD array.
// It generates PreCharge -> WL_enable -> Read/Write strobe timing and returns read
// data, or a zero write ack, over a valid/ready response port.
// Every output is a flop. Each output is loaded from the next-state decode, so it
// changes on the same edge as the state it belongs to.
module impact_array_seq #(
    parameter int DW        = 8,
    parameter int PRE_CYC   = 2,
    parameter int WL_CYC    = 1,
    parameter int SENSE_CYC = 2,
    parameter int WR_CYC    = 2
) (
    input  logic          clk,
    input  logic          rst,              // asynchronous, active low
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic          cmd_byte_mode,
    input  logic          cmd_trunc,
    input  logic [1:0]    cmd_byte_sel,
    input  logic [1:0]    cmd_proj_sel,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          PreCharge,
    output logic          WL_enable,
    output logic          ReadEnable,
    output logic          WriteEnable,
    output logic          Data_In_Enable,
    output logic          Byte_Mode_Enable,
    output logic          Trunc_Enable,
    output logic [1:0]    Byte_Select,
    output logic [1:0]    Proj_Select,
    output logic [DW-1:0] Data_In,
    input  logic [DW-1:0] Data_Out,
    output logic          busy
);

    // A phase length of zero is stretched to one cycle.
    localparam int PRE_N   = (PRE_CYC   < 1) ? 1 : PRE_CYC;
    localparam int WL_N    = (WL_CYC    < 1) ? 1 : WL_CYC;
    localparam int SENSE_N = (SENSE_CYC < 1) ? 1 : SENSE_CYC;
    localparam int WR_N    = (WR_CYC    < 1) ? 1 : WR_CYC;
    localparam int MAX_AB  = (PRE_N > WL_N) ? PRE_N : WL_N;
    localparam int MAX_CD  = (SENSE_N > WR_N) ? SENSE_N : WR_N;
    localparam int MAX_P   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(MAX_P) + 1;

    typedef enum logic [2:0] {IDLE, PRE, WL, ACC, RESP} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          write_reg, write_next;
    logic          accept;
    logic          phase_done;

    // cmd_ready is itself a flop, so this gate also blocks an accept in the first cycle after reset.
    assign accept     = (state_reg == IDLE) && cmd_ready && cmd_valid;
    assign phase_done = (cnt_reg <= CW'(1));

    // Next-state and phase-counter logic; the counter loads on phase entry and counts down to 1.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        write_next = write_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = PRE;
                    cnt_next   = CW'(PRE_N);
                    write_next = cmd_write;
                end
            end
            PRE: begin
                if (phase_done) begin
                    state_next = WL;
                    cnt_next   = CW'(WL_N);
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            WL: begin
                if (phase_done) begin
                    state_next = ACC;
                    cnt_next   = write_reg ? CW'(WR_N) : CW'(SENSE_N);
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            ACC: begin
                if (phase_done) begin
                    state_next = RESP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State, counter and strobe registers. Because the strobes decode a single state, break-before-make holds by construction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            write_reg      <= 1'b0;
            cmd_ready      <= 1'b0;
            busy           <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            PreCharge      <= 1'b0;
            WL_enable      <= 1'b0;
            ReadEnable     <= 1'b0;
            WriteEnable    <= 1'b0;
            Data_In_Enable <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            write_reg      <= write_next;
            cmd_ready      <= (state_next == IDLE);
            busy           <= (state_next != IDLE);
            rsp_valid      <= (state_next == RESP);
            PreCharge      <= (state_next == PRE);
            WL_enable      <= (state_next == WL) || (state_next == ACC);
            ReadEnable     <= (state_next == ACC) && !write_next;
            WriteEnable    <= (state_next == ACC) && write_next;
            Data_In_Enable <= (state_next == ACC) && write_next;
            // Array data is sampled on the edge that closes the last ACC cycle.
            if ((state_reg == ACC) && (state_next == RESP)) begin
                rsp_rdata <= write_reg ? '0 : Data_Out;
            end
        end
    end

    // Command fields are latched only on accept and then held until the next accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Byte_Mode_Enable <= 1'b0;
            Trunc_Enable     <= 1'b0;
            Byte_Select      <= '0;
            Proj_Select      <= '0;
            Data_In          <= '0;
        end else if (accept) begin
            Byte_Mode_Enable <= cmd_byte_mode;
            Trunc_Enable     <= cmd_trunc;
            Byte_Select      <= cmd_byte_sel;
            Proj_Select      <= cmd_proj_sel;
            Data_In          <= cmd_wdata;
        end
    end

endmodule

// File: tb/tb_impact_array_seq.sv
// tb_impact_array_seq: scoreboard bench for impact_array_seq.
// The expected response data is queued when a command is driven. It is popped on the
// response handshake. Strobe timing is checked cycle by cycle against the phase lengths.
module tb_impact_array_seq;

    localparam int DW  = 8;
    localparam int PRE = 2;
    localparam int WLC = 1;
    localparam int SEN = 2;
    localparam int WRC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic          cmd_byte_mode = 1'b0;
    logic          cmd_trunc = 1'b0;
    logic [1:0]    cmd_byte_sel = '0;
    logic [1:0]    cmd_proj_sel = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          PreCharge, WL_enable, ReadEnable, WriteEnable, Data_In_Enable;
    logic          Byte_Mode_Enable, Trunc_Enable;
    logic [1:0]    Byte_Select, Proj_Select;
    logic [DW-1:0] Data_In;
    logic [DW-1:0] Data_Out = '0;
    logic          busy;

    int            n_checks = 0;
    int            n_errors = 0;
    int            txn_id   = 0;
    logic [DW-1:0] exp_q[$];

    impact_array_seq #(
        .DW(DW), .PRE_CYC(PRE), .WL_CYC(WLC), .SENSE_CYC(SEN), .WR_CYC(WRC)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_byte_mode(cmd_byte_mode), .cmd_trunc(cmd_trunc),
        .cmd_byte_sel(cmd_byte_sel), .cmd_proj_sel(cmd_proj_sel), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .PreCharge(PreCharge), .WL_enable(WL_enable), .ReadEnable(ReadEnable),
        .WriteEnable(WriteEnable), .Data_In_Enable(Data_In_Enable),
        .Byte_Mode_Enable(Byte_Mode_Enable), .Trunc_Enable(Trunc_Enable),
        .Byte_Select(Byte_Select), .Proj_Select(Proj_Select), .Data_In(Data_In),
        .Data_Out(Data_Out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [4:0] strobes();
        return {PreCharge, WL_enable, ReadEnable, WriteEnable, Data_In_Enable};
    endfunction

    // Break-before-make must hold in every cycle the design is out of reset.
    always @(negedge clk) begin
        if (rst) begin
            check("bbm", {30'b0, PreCharge & WL_enable, ReadEnable & WriteEnable}, 32'd0);
        end
    end

    // Drive one command and follow it through to the response. If abort_c is nonzero,
    // reset is asserted in that cycle after the strobe checks, and the command is dropped.
    task automatic run_cmd(input logic wr, input logic bm, input logic tr,
                           input logic [1:0] bs, input logic [1:0] ps,
                           input logic [DW-1:0] wd, input logic [DW-1:0] dout,
                           input int stall, input int abort_c);
        int            total;
        logic [DW-1:0] exp_rd;
        logic [13:0]   fields;
        logic [4:0]    exp_s;
        bit            acc;
        total  = PRE + WLC + (wr ? WRC : SEN);
        exp_rd = wr ? '0 : dout;
        fields = {bm, tr, bs, ps, wd};
        txn_id++;

        @(negedge clk);
        check("idle_ready", {29'b0, cmd_ready, busy, rsp_valid}, 32'b100);
        cmd_valid = 1'b1; cmd_write = wr; cmd_byte_mode = bm; cmd_trunc = tr;
        cmd_byte_sel = bs; cmd_proj_sel = ps; cmd_wdata = wd;
        exp_q.push_back(exp_rd);

        @(negedge clk);
        // Scramble the command inputs; they must have no effect after the accept.
        cmd_valid = 1'b0; cmd_write = ~wr; cmd_byte_mode = ~bm; cmd_trunc = ~tr;
        cmd_byte_sel = ~bs; cmd_proj_sel = ~ps; cmd_wdata = ~wd;
        for (int c = 1; c <= total; c++) begin
            acc   = (c > PRE + WLC);
            exp_s = {(c <= PRE), (c > PRE), acc & ~wr, acc & wr, acc & wr};
            check("strobes", {27'b0, strobes()}, {27'b0, exp_s});
            check("busy_flags", {29'b0, cmd_ready, busy, rsp_valid}, 32'b010);
            check("fields", {18'b0, Byte_Mode_Enable, Trunc_Enable, Byte_Select, Proj_Select, Data_In},
                  {18'b0, fields});
            if (c == abort_c) begin
                rst = 1'b0;
                #1;
                check("rst_strobes", {27'b0, strobes()}, 32'd0);
                check("rst_flags", {29'b0, cmd_ready, busy, rsp_valid}, 32'd0);
                void'(exp_q.pop_back());
                $display("txn %0d: %s aborted by reset in cycle %0d", txn_id, wr ? "write" : "read", c);
                return;
            end
            Data_Out = acc ? dout : ~dout;
            @(negedge clk);
        end

        check("rsp_latency", {31'b0, rsp_valid}, 32'd1);
        for (int s = 0; s < stall; s++) begin
            check("stall_hold", {21'b0, rsp_valid, cmd_ready, busy, rsp_rdata},
                  {21'b0, 3'b101, exp_q[0]});
            check("stall_strobes", {27'b0, strobes()}, 32'd0);
            // Offer a new command while busy; it must not be latched.
            cmd_valid = 1'b1;
            Data_Out  = DW'($urandom);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int w = 0; w < 20 && !rsp_valid; w++) @(negedge clk);
        check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        if (exp_q.size() > 0) begin
            exp_rd = exp_q.pop_front();
            check("rsp_rdata", {24'b0, rsp_rdata}, {24'b0, exp_rd});
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_rsp", {29'b0, cmd_ready, busy, rsp_valid}, 32'b100);
        check("fields_kept", {18'b0, Byte_Mode_Enable, Trunc_Enable, Byte_Select, Proj_Select, Data_In},
              {18'b0, fields});
        $display("txn %0d: %s bsel=%b psel=%b wdata=%h stall=%0d rdata=%h expected=%h",
                 txn_id, wr ? "write" : "read ", bs, ps, wd, stall, rsp_rdata, exp_rd);
    endtask

    initial begin
        #1 rst = 1'b0;
        cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {2'b0, cmd_ready, rsp_valid, rsp_rdata, strobes(), Byte_Mode_Enable, Trunc_Enable,
               Byte_Select, Proj_Select, Data_In, busy}, 32'd0);
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("reset_release", {26'b0, cmd_ready, strobes()}, {26'b0, 1'b1, 5'b0});
        $display("txn 0: reset held 3 cycles and released");

        run_cmd(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 8'hA5, 0, 0);
        run_cmd(1'b1, 1'b1, 1'b1, 2'b10, 2'b01, 8'h3C, 8'hFF, 0, 0);
        run_cmd(1'b0, 1'b1, 1'b0, 2'b01, 2'b11, 8'h77, 8'h5A, 5, 0);
        run_cmd(1'b0, 1'b0, 1'b1, 2'b11, 2'b10, 8'h12, 8'h99, 0, 4);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_cmd(1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 8'h44, 8'hC3, 0, 0);
        for (int i = 0; i < 4; i++) begin
            run_cmd(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
                    8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
